// File: rtl/joy_shift_pkg.sv
// Shared types and helpers for the serial joystick shift-register reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package joy_shift_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_LO  = 3'd1,
        LOAD_HI  = 3'd2,
        SHIFT_LO = 3'd3,
        SHIFT_HI = 3'd4,
        UPDATE   = 3'd5,
        GAP      = 3'd6
    } joy_state_t;

    // Total number of serial bits in one frame across all daisy-chained pads.
    function automatic int total_bits(input int players, input int bits);
        return players * bits;
    endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Tick generator: single-cycle tick every CLK_DIV clocks while run is high.
// Latency: tick fires in the cycle the counter reaches CLK_DIV-1.
// Backpressure: none; run=0 parks the counter at 0 so the next phase starts aligned.
module joy_tick_gen #(
    parameter int CLK_DIV = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at CLK_DIV-1, held at zero whenever the reader is not pacing a phase.
    always_comb begin
        cnt_d = '0;
        tick  = (cnt_q == CNT_LAST);
        if (run && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/joy_shift_reader.sv
// Serial joystick reader: latches the adapter, shifts TOTAL bits out, publishes active-high buttons.
// Latency: frame period (2 + 2*TOTAL + FRAME_GAP)*CLK_DIV + 1 clks; joystick/frame_done update together.
// Backpressure: none; enable=0 aborts the frame to IDLE next clk. JOY_SHIFT_DEBOUNCE_EN adds two-frame agreement.
module joy_shift_reader
    import joy_shift_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int BITS_PER_PLAYER = 16,
    parameter int CLK_DIV         = 64,
    parameter int FRAME_GAP       = 256
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   joy_data,
    output logic                                   joy_clk,
    output logic                                   joy_load,
    output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joystick,
    output logic                                   frame_done
);

    localparam int TOTAL = total_bits(NUM_PLAYERS, BITS_PER_PLAYER);
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int GAP_W = $clog2(FRAME_GAP + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

    joy_state_t       state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TOTAL-1:0] shift_q, shift_d;
    logic [TOTAL-1:0] joystick_q, joystick_d;
    logic             frame_done_q, frame_done_d;
    logic             joy_clk_q, joy_clk_d;
    logic             joy_load_q, joy_load_d;
    logic             sync1_q, sync2_q;
    logic             run;
    logic             tick;
`ifdef JOY_SHIFT_DEBOUNCE_EN
    logic [TOTAL-1:0] prev_q, prev_d;
`endif

    // The phase counter only runs in tick-paced states; parking it in IDLE/UPDATE (and on abort)
    // guarantees every phase starts with a full CLK_DIV-cycle tick period.
    assign run = enable && (state_q != IDLE) && (state_q != UPDATE);

    joy_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .tick (tick)
    );

    // Two-flop synchroniser for the asynchronous adapter data line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= joy_data;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, datapath and strobe decode; strobes come from state_d so the pins are registered.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        gap_cnt_d    = gap_cnt_q;
        shift_d      = shift_q;
        joystick_d   = joystick_q;
        frame_done_d = 1'b0;
`ifdef JOY_SHIFT_DEBOUNCE_EN
        prev_d       = prev_q;
`endif
        if (!enable && (state_q != UPDATE)) begin
            // Abort: partial shift data is simply abandoned, joystick keeps its last frame.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = LOAD_LO;
                    bit_idx_d = '0;
                end
                LOAD_LO: begin
                    if (tick) state_d = LOAD_HI;
                end
                LOAD_HI: begin
                    if (tick) state_d = SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (tick) begin
                        for (int i = 0; i < TOTAL; i++) begin
                            if (bit_idx_q == IDX_W'(i)) shift_d[i] = sync2_q;
                        end
                        state_d = SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        if (bit_idx_q == IDX_LAST) begin
                            state_d = UPDATE;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                            state_d   = SHIFT_LO;
                        end
                    end
                end
                UPDATE: begin
                    // frame_done is registered so it rises with the new joystick word.
`ifdef JOY_SHIFT_DEBOUNCE_EN
                    if (shift_q == prev_q) joystick_d = ~shift_q;
                    prev_d = shift_q;
`else
                    joystick_d = ~shift_q;
`endif
                    frame_done_d = 1'b1;
                    gap_cnt_d    = '0;
                    bit_idx_d    = '0;
                    state_d      = enable ? GAP : IDLE;
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt_q == GAP_LAST) begin
                            state_d   = LOAD_LO;
                            bit_idx_d = '0;
                        end else begin
                            gap_cnt_d = gap_cnt_q + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        joy_clk_d  = (state_d != SHIFT_LO);
        joy_load_d = (state_d != LOAD_LO);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            gap_cnt_q    <= '0;
            shift_q      <= '0;
            joystick_q   <= '0;
            frame_done_q <= 1'b0;
            joy_clk_q    <= 1'b1;
            joy_load_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            shift_q      <= shift_d;
            joystick_q   <= joystick_d;
            frame_done_q <= frame_done_d;
            joy_clk_q    <= joy_clk_d;
            joy_load_q   <= joy_load_d;
        end
    end

`ifdef JOY_SHIFT_DEBOUNCE_EN
    // Previous raw frame, compared against the current one before publishing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`endif

    assign joy_clk    = joy_clk_q;
    assign joy_load   = joy_load_q;
    assign joystick   = joystick_q;
    assign frame_done = frame_done_q;

endmodule
